// File: rtl/ascii_hex_parser_pkg.sv
// Shared definitions for the ASCII hex token parser: character constants,
// default result width and the parser state encoding.
// Pure declarations, no logic.
package ascii_hex_parser_pkg;

  // Default result width; four bits per hex digit.
  localparam int DATA_WIDTH_DEF = 16;

  // Delimiters that terminate a token.
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  // Hex digit range boundaries.
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_UP_A  = 8'h41;
  localparam logic [7:0] CH_UP_F  = 8'h46;
  localparam logic [7:0] CH_LO_A  = 8'h61;
  localparam logic [7:0] CH_LO_F  = 8'h66;

  // Parser states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2,
    ST_SKIP  = 2'd3
  } state_t;

endpackage

// File: rtl/ascii_char_decode.sv
// Classifies one ASCII character as hex digit / delimiter / other and maps hex to a nibble.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle regardless of handshake.
module ascii_char_decode
  import ascii_hex_parser_pkg::*;
(
  input  logic [7:0] ch_i,
  output logic       is_hex_o,
  output logic       is_delim_o,
  output logic [3:0] nibble_o
);

  // Range checks; letters map as low nibble + 9 ('A'/'a' low nibble is 1).
  always_comb begin
    is_hex_o   = 1'b0;
    is_delim_o = 1'b0;
    nibble_o   = 4'd0;
    if (ch_i >= CH_0 && ch_i <= CH_9) begin
      is_hex_o = 1'b1;
      nibble_o = ch_i[3:0];
    end else if ((ch_i >= CH_UP_A && ch_i <= CH_UP_F) ||
                 (ch_i >= CH_LO_A && ch_i <= CH_LO_F)) begin
      is_hex_o = 1'b1;
      nibble_o = ch_i[3:0] + 4'd9;
    end else if (ch_i == CH_SPACE || ch_i == CH_CR ||
                 ch_i == CH_LF    || ch_i == CH_COMMA) begin
      is_delim_o = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_hex_parser.sv
// Parses delimiter-separated ASCII hex tokens into right-aligned values with a digit count.
// Latency: result valid the cycle after the terminating delimiter; oERR the cycle after a bad char.
// Backpressure: oRDY drops while a result waits for iREADY; no input accepted until it transfers.
module ascii_hex_parser
  import ascii_hex_parser_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [7:0]            iD,
  input  logic                  iVALID,
  output logic                  oRDY,
  output logic [DATA_WIDTH-1:0] oD,
  output logic [2:0]            oDIGITS,
  output logic                  oVALID,
  input  logic                  iREADY,
  output logic                  oERR
);

  localparam logic [2:0] MAX_DIGITS = 3'(DATA_WIDTH / 4);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;
  logic [2:0]            dig_q, dig_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;

  logic       is_hex;
  logic       is_delim;
  logic [3:0] nibble;
  logic       xfer;

  ascii_char_decode u_decode (
    .ch_i       (iD),
    .is_hex_o   (is_hex),
    .is_delim_o (is_delim),
    .nibble_o   (nibble)
  );

  // Input is only taken outside OUT, so a pending result blocks the stream.
  assign oRDY = (state_q != ST_OUT);
  assign xfer = iVALID & oRDY;

  // Next-state and datapath update for one accepted character or output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    od_d    = od_q;
    dig_d   = dig_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (is_hex) begin
            acc_d   = {{(DATA_WIDTH-4){1'b0}}, nibble};
            cnt_d   = 3'd1;
            state_d = ST_ACCUM;
          end else if (!is_delim) begin
            err_d   = 1'b1;
            state_d = ST_SKIP;
          end
        end
      end
      ST_ACCUM: begin
        if (xfer) begin
          if (is_hex && (cnt_q < MAX_DIGITS)) begin
            acc_d = {acc_q[DATA_WIDTH-5:0], nibble};
            cnt_d = cnt_q + 3'd1;
          end else if (is_delim) begin
            od_d    = acc_q;
            dig_d   = cnt_q;
            vld_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = 3'd0;
            state_d = ST_OUT;
          end else begin
            // Too many digits or a non-hex character: the whole token is bad.
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = 3'd0;
            state_d = ST_SKIP;
          end
        end
      end
      ST_OUT: begin
        if (iREADY) begin
          vld_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end
      end
      ST_SKIP: begin
        // Rest of a bad token is swallowed silently up to the next delimiter.
        if (xfer && is_delim) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any partial or pending result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= 3'd0;
      od_q    <= '0;
      dig_q   <= 3'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      od_q    <= od_d;
      dig_q   <= dig_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign oD      = od_q;
  assign oDIGITS = dig_q;
  assign oVALID  = vld_q;
  assign oERR    = err_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed bench for the ASCII hex parser: token strings with hand-computed results.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// A negedge monitor collects transferred results and counts oERR cycles.
module tb_ascii_hex_parser;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  iD;
  logic        iVALID;
  logic        oRDY;
  logic [15:0] oD;
  logic [2:0]  oDIGITS;
  logic        oVALID;
  logic        iREADY;
  logic        oERR;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] res_q[$];
  logic [2:0]  dig_q[$];
  int          err_cnt = 0;

  ascii_hex_parser #(.DATA_WIDTH(16)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .iD      (iD),
    .iVALID  (iVALID),
    .oRDY    (oRDY),
    .oD      (oD),
    .oDIGITS (oDIGITS),
    .oVALID  (oVALID),
    .iREADY  (iREADY),
    .oERR    (oERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Record every completed output handshake and every cycle with oERR high.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (oVALID && iREADY) begin
        res_q.push_back(oD);
        dig_q.push_back(oDIGITS);
      end
      if (oERR) err_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    res_q.delete();
    dig_q.delete();
    err_cnt = 0;
  endtask

  task automatic send_char(input logic [7:0] c);
    bit done;
    done   = 1'b0;
    iD     = c;
    iVALID = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge CLK);
      if (oRDY) done = 1'b1;
      @(posedge CLK);
      #1;
    end
    if (!done) check_eq("accept_timeout", {31'd0, oRDY}, 32'd1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    iVALID = 1'b0;
    iD     = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_one_result(input string tag, input logic [15:0] v, input logic [2:0] d);
    check_eq({tag, "_count"}, res_q.size(), 1);
    if (res_q.size() > 0) begin
      check_eq({tag, "_oD"}, {16'd0, res_q[0]}, {16'd0, v});
      check_eq({tag, "_digits"}, {29'd0, dig_q[0]}, {29'd0, d});
    end
  endtask

  initial begin
    RST_N  = 1'b0;
    iD     = 8'h00;
    iVALID = 1'b0;
    iREADY = 1'b1;
    #12;
    check_eq("rst_oVALID", {31'd0, oVALID}, 0);
    check_eq("rst_oRDY",   {31'd0, oRDY}, 1);
    check_eq("rst_oERR",   {31'd0, oERR}, 0);
    check_eq("rst_oD",     {16'd0, oD}, 0);
    check_eq("rst_oDIGITS",{29'd0, oDIGITS}, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    idle_cycles(2);

    // Full-width token, CR terminated, downstream always ready.
    clear_mon();
    send_str("1A3f\r");
    idle_cycles(4);
    check_one_result("t1", 16'h1A3F, 3'd4);
    check_eq("t1_err", err_cnt, 0);

    // Stalled output: value held for five cycles, input blocked.
    clear_mon();
    iREADY = 1'b0;
    send_str("7 ");
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check_eq("t2_stall_vld", {31'd0, oVALID}, 1);
      check_eq("t2_stall_rdy", {31'd0, oRDY}, 0);
      check_eq("t2_stall_oD",  {16'd0, oD}, 32'h0007);
      check_eq("t2_stall_dig", {29'd0, oDIGITS}, 1);
    end
    @(posedge CLK); #1;
    iREADY = 1'b1;
    idle_cycles(4);
    check_one_result("t2", 16'h0007, 3'd1);
    @(negedge CLK);
    check_eq("t2_after_vld", {31'd0, oVALID}, 0);
    check_eq("t2_after_rdy", {31'd0, oRDY}, 1);

    // Overflow on the fifth digit, then a good token.
    clear_mon();
    send_str("12345,");
    idle_cycles(3);
    check_eq("t3_err", err_cnt, 1);
    check_eq("t3_nores", res_q.size(), 0);
    send_str("BEEF\n");
    idle_cycles(4);
    check_one_result("t3b", 16'hBEEF, 3'd4);
    check_eq("t3b_err", err_cnt, 1);

    // Bad character mid-token; remainder skipped, next token parsed.
    clear_mon();
    send_str("4G2 9\n");
    idle_cycles(4);
    check_eq("t4_err", err_cnt, 1);
    check_one_result("t4", 16'h0009, 3'd1);

    // Delimiter runs produce exactly one result.
    clear_mon();
    send_str("\r\n,  ab\r\n");
    idle_cycles(4);
    check_one_result("t5", 16'h00AB, 3'd2);
    check_eq("t5_err", err_cnt, 0);

    // Reset mid-token and while a result is pending.
    clear_mon();
    send_str("12");
    RST_N = 1'b0;
    #1;
    check_eq("t6_rst1_vld", {31'd0, oVALID}, 0);
    check_eq("t6_rst1_rdy", {31'd0, oRDY}, 1);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    idle_cycles(2);
    iREADY = 1'b0;
    send_str("5\r");
    @(negedge CLK);
    check_eq("t6_pending_vld", {31'd0, oVALID}, 1);
    RST_N = 1'b0;
    #1;
    check_eq("t6_rst2_vld", {31'd0, oVALID}, 0);
    check_eq("t6_rst2_oD",  {16'd0, oD}, 0);
    @(posedge CLK); #1;
    RST_N  = 1'b1;
    iREADY = 1'b1;
    idle_cycles(3);
    check_eq("t6_nores", res_q.size(), 0);
    send_str("C\r");
    idle_cycles(4);
    check_one_result("t6", 16'h000C, 3'd1);
    check_eq("t6_err", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ascii_hex_parser.md
ASCII_HEX_PARSER -- requirements
Module: ascii_hex_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: result width; maximum digit count MAX_DIGITS = DATA_WIDTH/4 (4 by default).
REQ-002 SHALL have port CLK  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port RST_N  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port iD  input  8  ASCII character.
REQ-005 SHALL have port iVALID  input  1  iD valid.
REQ-006 SHALL have port oRDY  output  1  parser accepts iD; a character transfers on a cycle with iVALID=1 and oRDY=1.
REQ-007 SHALL have port oD  output  DATA_WIDTH  parsed value, right-aligned, zero-extended.
REQ-008 SHALL have port oDIGITS  output  3  number of hex digits in oD (1..MAX_DIGITS).
REQ-009 SHALL have port oVALID  output  1  oD/oDIGITS valid.
REQ-010 SHALL have port iREADY  input  1  downstream accepts oD; a result transfers on a cycle with oVALID=1 and iREADY=1.
REQ-011 SHALL have port oERR  output  1  one-cycle pulse on a malformed token.

Function
REQ-012 Character classes: HEX = '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66); DELIM = 0x20 space, 0x0D CR, 0x0A LF, 0x2C comma; OTHER = everything else.
REQ-013 HEX nibble mapping: '0'-'9' -> 0-9; 'A'-'F' and 'a'-'f' -> 10-15.
REQ-014 State machine SHALL have exactly the states IDLE, ACCUM, OUT and SKIP.
REQ-015 oRDY SHALL be 1 in IDLE, ACCUM and SKIP, and 0 in OUT.
REQ-016 IDLE: on HEX -> acc <= nibble, cnt <= 1, go to ACCUM; DELIM -> ignored, stay in IDLE; OTHER -> oERR pulse, go to SKIP.
REQ-017 ACCUM: HEX with cnt < MAX_DIGITS -> acc <= {acc[DATA_WIDTH-5:0], nibble}, cnt <= cnt+1.
REQ-018 ACCUM: DELIM -> oD <= acc, oDIGITS <= cnt, oVALID <= 1, go to OUT.
REQ-019 ACCUM: HEX with cnt == MAX_DIGITS (overflow) or OTHER -> oERR pulse, acc/cnt discarded, go to SKIP.
REQ-020 SKIP: discard every character until a DELIM; on DELIM go to IDLE with no result and no additional oERR.
REQ-021 OUT: hold oD, oDIGITS and oVALID stable until the handshake completes; on handshake, in the next cycle oVALID=0 and state is IDLE with acc=0, cnt=0.
REQ-022 Latency: delimiter accepted in cycle N -> oVALID=1 in cycle N+1; iREADY is allowed to be high already in cycle N+1.
REQ-023 There SHALL be no input transfer in a handshake cycle (oRDY=0 in OUT); the first character after a result is accepted in cycle N+2 at the earliest.
REQ-024 oERR SHALL be registered and asserted for exactly the cycle after the offending character is accepted.
REQ-025 iD SHALL be ignored when iVALID=0 or oRDY=0; the state SHALL not change.
REQ-026 A delimiter run (e.g. CR LF) SHALL yield exactly one result per token.

Reset
REQ-027 On RST_N=0, immediately: state IDLE, acc=0, cnt=0, oD=0, oDIGITS=0, oVALID=0, oERR=0; oRDY=1 follows from IDLE.
REQ-028 Reset mid-token or in OUT SHALL drop the partial or pending result with no output.

Structure
REQ-029 A shared package SHALL hold the ASCII constants (delimiters, '0', 'A', 'a', '9', 'F', 'f'), DATA_WIDTH default, and the state encoding.
REQ-030 Character classification and nibble mapping SHALL be one combinational sub-module, ascii_char_decode (inputs: 8-bit char; outputs: is_hex, is_delim, 4-bit nibble).

Verification
REQ-031 Send "1A3f\r" with iREADY=1 -> oVALID for one cycle, oD=0x1A3F, oDIGITS=4, oERR never asserted.
REQ-032 Send "7 " with iREADY held 0 for 5 cycles -> oD=0x0007, oDIGITS=1 held stable with oVALID=1 and oRDY=0 for the whole stall; one transfer when iREADY rises.
REQ-033 Send "12345," -> oERR pulses once after '5', no result; then send "BEEF\n" -> oD=0xBEEF.
REQ-034 Send "4G2 9\n" -> oERR once after 'G', "2" discarded, then one result oD=0x0009.
REQ-035 Send "\r\n,  ab\r\n" -> exactly one result, oD=0x00AB, oDIGITS=2.
REQ-036 Assert RST_N=0 after "12" and again while in OUT -> no oVALID; after release "C\r" gives oD=0x000C.
